// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - frame-divided multi-lane move scheduler
// Lanes expire on frame wraps and owe a move; moves are granted round-robin one at a time.
module move_scheduler #(
   parameter int NUM_LANES    = 4,
   parameter int DIV_WIDTH    = 20,
   parameter int FRAME_DIV    = 833333,
   parameter int PERIOD_WIDTH = 6,
   localparam int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic [NUM_LANES*PERIOD_WIDTH-1:0] lane_period,
   input  logic                              clr_overrun,
   input  logic                              move_ready,
   input  logic                              upd_done,
   output logic                              frame_tick,
   output logic                              move_valid,
   output logic [LANE_W-1:0]                 move_lane,
   output logic [NUM_LANES-1:0]              pending,
   output logic [NUM_LANES-1:0]              overrun,
   output logic                              busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

   state_t                  state_q, state_d;
   logic [DIV_WIDTH-1:0]    div_cnt_q, div_cnt_d;
   logic [PERIOD_WIDTH-1:0] cnt_q [NUM_LANES];
   logic [PERIOD_WIDTH-1:0] cnt_d [NUM_LANES];
   logic [NUM_LANES-1:0]    pending_q, pending_d;
   logic [NUM_LANES-1:0]    overrun_q, overrun_d;
   logic [LANE_W-1:0]       last_grant_q, last_grant_d;
   logic [LANE_W-1:0]       move_lane_q, move_lane_d;
   logic                    move_valid_q, move_valid_d;
   logic                    frame_tick_q, frame_tick_d;

   always_comb begin
      logic                    wrap;
      logic                    hs;
      logic                    found;
      logic [NUM_LANES-1:0]    expire;
      logic [NUM_LANES-1:0]    clr_mask;
      logic [PERIOD_WIDTH-1:0] period;
      logic [LANE_W-1:0]       pick;
      int                      idx;

      state_d      = state_q;
      last_grant_d = last_grant_q;
      move_lane_d  = move_lane_q;
      move_valid_d = move_valid_q;
      expire       = '0;
      found        = 1'b0;
      pick         = '0;
      period       = '0;
      idx          = 0;

      wrap         = en && (div_cnt_q == DIV_WIDTH'(FRAME_DIV - 1));
      frame_tick_d = wrap;
      if (!en)
         div_cnt_d = div_cnt_q;
      else if (wrap)
         div_cnt_d = '0;
      else
         div_cnt_d = div_cnt_q + DIV_WIDTH'(1);

      // Period is only looked at on reload, so a new value lands at the next expiry.
      for (int i = 0; i < NUM_LANES; i++) begin
         period   = lane_period[i*PERIOD_WIDTH +: PERIOD_WIDTH];
         cnt_d[i] = cnt_q[i];
         if (wrap) begin
            if (period == '0) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] <= PERIOD_WIDTH'(1)) begin
               expire[i] = 1'b1;
               cnt_d[i]  = period;
            end else begin
               cnt_d[i] = cnt_q[i] - PERIOD_WIDTH'(1);
            end
         end
      end

      hs        = (state_q == S_REQ) && move_valid_q && move_ready;
      clr_mask  = hs ? (NUM_LANES'(1) << move_lane_q) : '0;
      pending_d = (pending_q & ~clr_mask) | expire;
      overrun_d = (clr_overrun ? '0 : overrun_q) | (expire & pending_q & ~clr_mask);

      for (int k = 1; k <= NUM_LANES; k++) begin
         idx = int'(last_grant_q) + k;
         if (idx >= NUM_LANES)
            idx = idx - NUM_LANES;
         if (!found && pending_q[LANE_W'(idx)]) begin
            found = 1'b1;
            pick  = LANE_W'(idx);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (found) begin
               move_lane_d  = pick;
               move_valid_d = 1'b1;
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            if (hs) begin
               last_grant_d = move_lane_q;
               move_valid_d = 1'b0;
               state_d      = S_BUSY;
            end
         end
         S_BUSY: begin
            move_valid_d = 1'b0;
            if (upd_done)
               state_d = S_IDLE;
         end
         default: begin
            move_valid_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         div_cnt_q    <= '0;
         pending_q    <= '0;
         overrun_q    <= '0;
         last_grant_q <= LANE_W'(NUM_LANES - 1);
         move_lane_q  <= '0;
         move_valid_q <= 1'b0;
         frame_tick_q <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++)
            cnt_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         last_grant_q <= last_grant_d;
         move_lane_q  <= move_lane_d;
         move_valid_q <= move_valid_d;
         frame_tick_q <= frame_tick_d;
         for (int i = 0; i < NUM_LANES; i++)
            cnt_q[i] <= cnt_d[i];
      end
   end

   assign frame_tick = frame_tick_q;
   assign move_valid = move_valid_q;
   assign move_lane  = move_lane_q;
   assign pending    = pending_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter NUM_LANES, default 4: number of independently timed lanes, legal range 2..8.
REQ-002 Parameter DIV_WIDTH, default 20: width of the frame divider counter.
REQ-003 Parameter FRAME_DIV, default 833333: clock cycles per frame tick, legal range 2..2^DIV_WIDTH.
REQ-004 Parameter PERIOD_WIDTH, default 6: width of each lane period field.
REQ-005 LANE_W = max(1, clog2(NUM_LANES)) is derived, not overridable.
REQ-006 clk  input  1: single clock; all logic on rising edge.
REQ-007 rst  input  1: synchronous, active-high reset.
REQ-008 en  input  1: frame divider enable; low freezes the divider.
REQ-009 lane_period  input  NUM_LANES*PERIOD_WIDTH: lane i period in frames at bits [i*PERIOD_WIDTH +: PERIOD_WIDTH]; 0 disables lane i.
REQ-010 clr_overrun  input  1: one-cycle pulse clearing all overrun flags.
REQ-011 move_ready  input  1: update engine accepts the offered move.
REQ-012 upd_done  input  1: one-cycle pulse, update engine finished the accepted move.
REQ-013 frame_tick  output  1: one-cycle frame pulse.
REQ-014 move_valid  output  1: move request offered to update engine.
REQ-015 move_lane  output  LANE_W: lane index of offered move.
REQ-016 pending  output  NUM_LANES: per-lane move-owed flags.
REQ-017 overrun  output  NUM_LANES: sticky per-lane missed-move flags.
REQ-018 busy  output  1: high whenever FSM is not IDLE.

Function
REQ-019 Divider div_cnt: when en=1, increments by 1; at FRAME_DIV-1 wraps to 0 (wrap event); when en=0, holds.
REQ-020 frame_tick SHALL be high exactly the cycle after each wrap event (registered), low otherwise.
REQ-021 Lane counter cnt[i] (PERIOD_WIDTH bits), updated only on wrap events.
REQ-022 On wrap, period P=0: cnt[i] <= 0, no expiry.
REQ-023 On wrap, P>0 and cnt[i]<=1: expiry of lane i, cnt[i] <= P.
REQ-024 On wrap, P>0 and cnt[i]>1: cnt[i] <= cnt[i]-1; period P therefore yields one expiry every P wraps; first wrap after reset always expires an enabled lane.
REQ-025 lane_period is sampled only at reload; changes take effect at next expiry; changing to 0 disables at next wrap.
REQ-026 Expiry sets pending[i] at the next edge; a handshake on lane i clears pending[i]; expiry and clear on the same lane in the same cycle leaves pending[i]=1.
REQ-027 Expiry while pending[i]=1 and not being cleared that cycle SHALL set overrun[i]; overrun clears only on rst or clr_overrun; set wins over simultaneous clr_overrun.
REQ-028 FSM states IDLE, REQ, BUSY; reset state IDLE.
REQ-029 IDLE: if pending!=0, select lane by round-robin starting at last_grant+1 (mod NUM_LANES), load move_lane, assert move_valid, go REQ; else stay.
REQ-030 REQ: move_valid and move_lane held stable until move_ready=1; handshake = move_valid&move_ready; on handshake clear that pending bit, last_grant <= move_lane, deassert move_valid, go BUSY.
REQ-031 BUSY: on upd_done go IDLE; move_valid stays 0.
REQ-032 upd_done outside BUSY and move_ready outside REQ SHALL be ignored.
REQ-033 Latency: expiry at edge T -> pending visible after T -> move_valid high no earlier than two cycles after the wrap cycle.
REQ-034 en=0 SHALL NOT stall the FSM; already-pending moves are still issued.
REQ-035 At most one move outstanding at any time.

Reset
REQ-036 rst=1 at an edge: div_cnt=0, cnt[*]=0, pending=0, overrun=0, last_grant=NUM_LANES-1, state IDLE, frame_tick=0, move_valid=0, move_lane=0, busy=0.
REQ-037 Reset mid-operation (REQ or BUSY) abandons the move; no pending bit survives; rst overrides all other inputs.

Verification (NUM_LANES=4, FRAME_DIV=4, PERIOD_WIDTH=6)
REQ-038 en=1, periods {1,2,0,3}, move_ready=1, upd_done one cycle after accept: frame_tick every 4 cycles; lanes 0,1,3 expire on wrap 1; lane 0 every wrap, lane 1 every 2nd, lane 3 every 3rd; lane 2 never granted.
REQ-039 Lanes 0..3 pending simultaneously, last_grant=3: grants in order 0,1,2,3; after grant of lane 1, next grant starts search at 2.
REQ-040 move_ready held 0 for 10 cycles in REQ: move_valid and move_lane stable throughout; accept on first cycle move_ready=1.
REQ-041 Period 1 on lane 0, upd_done withheld 12 cycles: pending[0] stays 1, overrun[0]=1 after second expiry; clr_overrun pulse clears it to 0.
REQ-042 en=0 for 20 cycles with pending[2]=1: no frame_tick, div_cnt frozen, lane 2 still granted and completed.
REQ-043 rst asserted in BUSY: next cycle state IDLE, busy=0, pending=0, overrun=0, div_cnt=0.
